// File: rtl/core_ctrl_pkg.sv
// Shared constants and FSM state types for the per-core control register AXI slave.
package core_ctrl_pkg;

    localparam logic [12:0] CTRL_OFFSET = 13'h1FFF;
    localparam int unsigned RESET_BIT   = 56;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WIdle,
        WData,
        WResp
    } wr_state_e;

    typedef enum logic {
        RIdle,
        RData
    } rd_state_e;

endpackage

// File: rtl/core_ctrl_regfile.sv
// Per-core control registers: reset bit plus 32-bit scratch, byte-strobed write port and
// combinational read port.
module core_ctrl_regfile
    import core_ctrl_pkg::*;
#(
    parameter int unsigned RISCV_CORES   = 8,
    parameter int unsigned CORE_NO_WIDTH = $clog2(RISCV_CORES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_we,
    input  logic [CORE_NO_WIDTH-1:0]      i_wr_core,
    input  logic [63:0]                   i_wdata,
    input  logic [7:0]                    i_wstrb,
    input  logic [CORE_NO_WIDTH-1:0]      i_rd_core,
    output logic [63:0]                   o_rdata,
    output logic [RISCV_CORES-1:0]        o_core_reset,
    output logic [RISCV_CORES*32-1:0]     o_core_scratch
);

    logic [RISCV_CORES-1:0] r_reset;
    logic [31:0]            r_scratch [RISCV_CORES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reset <= '1;
            for (int i = 0; i < RISCV_CORES; i++) begin
                r_scratch[i] <= '0;
            end
        end else if (i_we) begin
            if (i_wstrb[RESET_BIT/8]) begin
                r_reset[i_wr_core] <= i_wdata[RESET_BIT];
            end
            for (int b = 0; b < 4; b++) begin
                if (i_wstrb[b]) begin
                    r_scratch[i_wr_core][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        o_rdata            = '0;
        o_rdata[RESET_BIT] = r_reset[i_rd_core];
        o_rdata[31:0]      = r_scratch[i_rd_core];
    end

    always_comb begin
        o_core_scratch = '0;
        for (int i = 0; i < RISCV_CORES; i++) begin
            o_core_scratch[32*i +: 32] = r_scratch[i];
        end
    end

    assign o_core_reset = r_reset;

    // Bits outside the reset bit and scratch bytes have no storage.
    logic w_unused;
    assign w_unused = ^{i_wstrb[6:4], i_wdata[63:57], i_wdata[55:32]};

endmodule

// File: rtl/core_ctrl_axi_slave.sv
// AXI4 slave terminating per-core control writes/reads; one control register per core
// at core-region offset 0xFFF8.
module core_ctrl_axi_slave
    import core_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned ADDR_WIDTH    = 19,
    parameter int unsigned ID_WIDTH      = 8,
    parameter int unsigned RISCV_CORES   = 8,
    parameter int unsigned CORE_NO_WIDTH = $clog2(RISCV_CORES),
    parameter int unsigned STRB_WIDTH    = DATA_WIDTH/8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ID_WIDTH-1:0]       s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awlock,
    input  logic [3:0]                s_axi_awcache,
    input  logic [2:0]                s_axi_awprot,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [STRB_WIDTH-1:0]     s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [ID_WIDTH-1:0]       s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [ID_WIDTH-1:0]       s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arlock,
    input  logic [3:0]                s_axi_arcache,
    input  logic [2:0]                s_axi_arprot,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [ID_WIDTH-1:0]       s_axi_rid,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [RISCV_CORES-1:0]    core_reset,
    output logic [RISCV_CORES*32-1:0] core_scratch,
    output logic                      ctrl_wr_pulse,
    output logic [CORE_NO_WIDTH-1:0]  ctrl_wr_core
);

    wr_state_e r_wstate, w_wstate_d;
    rd_state_e r_rstate, w_rstate_d;

    logic                     r_awready, r_wready, r_bvalid, r_wr_pulse;
    logic [ID_WIDTH-1:0]      r_awid;
    logic [ADDR_WIDTH-1:0]    r_awaddr;
    logic [7:0]               r_awlen, r_wcnt;
    logic [1:0]               r_bresp, w_bresp_d;
    logic [CORE_NO_WIDTH-1:0] r_wr_core;
    logic                     w_commit;

    logic                     r_arready, r_rvalid;
    logic [ID_WIDTH-1:0]      r_rid;
    logic [7:0]               r_arlen, r_rcnt;
    logic [DATA_WIDTH-1:0]    r_rdata, w_rdata_cap;
    logic [1:0]               r_rresp, w_rresp_cap;
    logic [63:0]              w_rf_rdata;

    logic w_aw_hs, w_w_hs, w_ar_hs, w_r_hs, w_rlast;
    logic w_wcore_ok, w_woff_ok, w_rcore_ok;
    logic [CORE_NO_WIDTH-1:0] w_wcore, w_rcore;

    assign w_aw_hs = s_axi_awvalid && r_awready;
    assign w_w_hs  = s_axi_wvalid && r_wready;
    assign w_ar_hs = s_axi_arvalid && r_arready;
    assign w_r_hs  = r_rvalid && s_axi_rready;
    assign w_rlast = (r_rcnt == r_arlen);

    assign w_wcore    = r_awaddr[16 +: CORE_NO_WIDTH];
    assign w_wcore_ok = 32'(r_awaddr[ADDR_WIDTH-1:16]) < RISCV_CORES;
    assign w_woff_ok  = (r_awaddr[15:3] == CTRL_OFFSET);
    assign w_rcore    = s_axi_araddr[16 +: CORE_NO_WIDTH];
    assign w_rcore_ok = 32'(s_axi_araddr[ADDR_WIDTH-1:16]) < RISCV_CORES;

    // Write FSM next state; commit only for a clean single-beat write to the control word.
    always_comb begin
        w_wstate_d = r_wstate;
        w_bresp_d  = r_bresp;
        w_commit   = 1'b0;
        unique case (r_wstate)
            WIdle: begin
                if (w_aw_hs) w_wstate_d = WData;
            end
            WData: begin
                if (w_w_hs && s_axi_wlast) begin
                    w_wstate_d = WResp;
                    if (!w_wcore_ok) begin
                        w_bresp_d = RESP_DECERR;
                    end else if (r_awlen != 8'd0 || r_wcnt != r_awlen) begin
                        w_bresp_d = RESP_SLVERR;
                    end else begin
                        w_bresp_d = RESP_OKAY;
                        w_commit  = w_woff_ok;
                    end
                end
            end
            WResp: begin
                if (r_bvalid && s_axi_bready) w_wstate_d = WIdle;
            end
            default: w_wstate_d = WIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate   <= WIdle;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_awid     <= '0;
            r_awaddr   <= '0;
            r_awlen    <= '0;
            r_wcnt     <= '0;
            r_wr_pulse <= 1'b0;
            r_wr_core  <= '0;
        end else begin
            r_wstate   <= w_wstate_d;
            r_awready  <= (w_wstate_d == WIdle);
            r_wready   <= (w_wstate_d == WData);
            r_bvalid   <= (w_wstate_d == WResp);
            r_bresp    <= w_bresp_d;
            r_wr_pulse <= w_commit;
            if (w_commit) r_wr_core <= w_wcore;
            if (w_aw_hs) begin
                r_awid   <= s_axi_awid;
                r_awaddr <= s_axi_awaddr;
                r_awlen  <= s_axi_awlen;
                r_wcnt   <= '0;
            end else if (w_w_hs) begin
                r_wcnt <= r_wcnt + 8'd1;
            end
        end
    end

    // Read data is snapshotted at AR acceptance, so a same-edge commit is not visible.
    always_comb begin
        w_rdata_cap = '0;
        w_rresp_cap = RESP_OKAY;
        if (s_axi_arlen != 8'd0) begin
            w_rresp_cap = RESP_SLVERR;
        end else if (!w_rcore_ok) begin
            w_rresp_cap = RESP_DECERR;
        end else if (s_axi_araddr[15:3] == CTRL_OFFSET) begin
            w_rdata_cap = w_rf_rdata;
        end
    end

    always_comb begin
        w_rstate_d = r_rstate;
        unique case (r_rstate)
            RIdle: if (w_ar_hs) w_rstate_d = RData;
            RData: if (w_r_hs && w_rlast) w_rstate_d = RIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate  <= RIdle;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rid     <= '0;
            r_arlen   <= '0;
            r_rcnt    <= '0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_rstate  <= w_rstate_d;
            r_arready <= (w_rstate_d == RIdle);
            r_rvalid  <= (w_rstate_d == RData);
            if (w_ar_hs) begin
                r_rid   <= s_axi_arid;
                r_arlen <= s_axi_arlen;
                r_rcnt  <= '0;
                r_rdata <= w_rdata_cap;
                r_rresp <= w_rresp_cap;
            end else if (w_r_hs) begin
                r_rcnt <= r_rcnt + 8'd1;
            end
        end
    end

    core_ctrl_regfile #(
        .RISCV_CORES   (RISCV_CORES),
        .CORE_NO_WIDTH (CORE_NO_WIDTH)
    ) u_regfile (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_we           (w_commit),
        .i_wr_core      (w_wcore),
        .i_wdata        (s_axi_wdata),
        .i_wstrb        (s_axi_wstrb),
        .i_rd_core      (w_rcore),
        .o_rdata        (w_rf_rdata),
        .o_core_reset   (core_reset),
        .o_core_scratch (core_scratch)
    );

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bid     = r_awid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_arready = r_arready;
    assign s_axi_rid     = r_rid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rlast   = r_rvalid && w_rlast;
    assign s_axi_rvalid  = r_rvalid;
    assign ctrl_wr_pulse = r_wr_pulse;
    assign ctrl_wr_core  = r_wr_core;

    logic w_unused;
    assign w_unused = ^{s_axi_awsize, s_axi_awburst, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                        s_axi_arsize, s_axi_arburst, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                        r_awaddr[2:0], s_axi_araddr[2:0]};

endmodule
